// File: rtl/norm_engine.sv
// Streaming LayerNorm / RMSNorm engine.
// Buffers one row, derives mean and rsqrt(var), then streams scaled outputs.
module norm_engine #(
  parameter int DATA_WIDTH     = 8,
  parameter int ACC_WIDTH      = 32,
  parameter int MAX_HIDDEN_DIM = 64,
  parameter int LUT_DEPTH      = 1024,
  parameter int GAMMA_FRAC     = 6,
  parameter int IDXW           = $clog2(MAX_HIDDEN_DIM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode_rms,
  input  logic [IDXW:0]         hidden_dim,
  input  logic                  clear,
  output logic                  busy,
  output logic                  done,
  input  logic                  param_we,
  input  logic [IDXW-1:0]       param_addr,
  input  logic [DATA_WIDTH-1:0] gamma_in,
  input  logic [DATA_WIDTH-1:0] beta_in,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int W2    = 2 * ACC_WIDTH;
  localparam int LIDXW = $clog2(LUT_DEPTH);
  localparam logic [IDXW:0] MAXN =
    (IDXW+1)'(MAX_HIDDEN_DIM);
  localparam logic signed [W2-1:0] SMAX =
    W2'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [W2-1:0] SMIN =
    W2'(-(2**(DATA_WIDTH-1)));
  localparam logic signed [ACC_WIDTH-1:0] LMAX =
    ACC_WIDTH'(LUT_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STATS1,
    S_STATS2, S_NORM, S_FINISH
  } state_t;

  // Largest m with k*(2m-1)^2 <= 2^34, i.e. round(65536/sqrt(k)).
  function automatic logic [31:0] rsq(input int k);
    logic [63:0] lo, hi, mid, t, kk;
    kk = 64'(k);
    lo = 64'd1;
    hi = 64'd65536;
    for (int it = 0; it < 18; it++) begin
      mid = (lo + hi + 64'd1) >> 1;
      t   = (mid << 1) - 64'd1;
      if (kk * t * t <= 64'h4_0000_0000) lo = mid;
      else hi = mid - 64'd1;
    end
    return lo[31:0];
  endfunction

  logic [31:0] w_lut [LUT_DEPTH];

  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
    localparam logic [31:0] LV = rsq(g + 1);
    assign w_lut[g] = LV;
  end

  state_t r_state, w_next;

  logic                         r_rms;
  logic [IDXW:0]                r_n;
  logic [IDXW:0]                r_cnt;
  logic [IDXW:0]                r_rd;
  logic [IDXW:0]                r_oc;
  logic signed [ACC_WIDTH-1:0]  r_sum;
  logic [ACC_WIDTH-1:0]         r_sumsq;
  logic signed [ACC_WIDTH-1:0]  r_mean;
  logic [ACC_WIDTH-1:0]         r_msq;
  logic [31:0]                  r_rs;
  logic [DATA_WIDTH-1:0]        r_out;
  logic                         r_ovld;

  logic [DATA_WIDTH-1:0] r_buf   [MAX_HIDDEN_DIM];
  logic [DATA_WIDTH-1:0] r_gamma [MAX_HIDDEN_DIM];
  logic [DATA_WIDTH-1:0] r_beta  [MAX_HIDDEN_DIM];

  logic                          w_in_hs;
  logic                          w_out_hs;
  logic                          w_last_in;
  logic                          w_last_out;
  logic                          w_load_out;
  logic [IDXW:0]                 w_n_lat;
  logic signed [2*DATA_WIDTH-1:0] w_sq;
  logic [ACC_WIDTH-1:0]          w_div;
  logic signed [ACC_WIDTH-1:0]   w_mean;
  logic [ACC_WIDTH-1:0]          w_msq;
  logic signed [ACC_WIDTH-1:0]   w_var;
  logic signed [ACC_WIDTH-1:0]   w_varc;
  logic [LIDXW-1:0]              w_idx;
  logic [DATA_WIDTH-1:0]         w_xr;
  logic [DATA_WIDTH-1:0]         w_gr;
  logic [DATA_WIDTH-1:0]         w_br;
  logic signed [W2-1:0]          w_diff;
  logic signed [W2-1:0]          w_rsx;
  logic signed [W2-1:0]          w_gx;
  logic signed [W2-1:0]          w_bx;
  logic signed [W2-1:0]          w_nprod;
  logic signed [W2-1:0]          w_n;
  logic signed [W2-1:0]          w_sprod;
  logic signed [W2-1:0]          w_s;
  logic signed [W2-1:0]          w_y;
  logic [DATA_WIDTH-1:0]         w_sat;

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FINISH);
  assign in_ready  = (r_state == S_LOAD);
  assign out_data  = r_out;
  assign out_valid = r_ovld;

  assign w_in_hs    = in_valid && in_ready;
  assign w_out_hs   = r_ovld && out_ready;
  assign w_last_in  = w_in_hs && (r_cnt == r_n - 1'b1);
  assign w_last_out = w_out_hs && (r_oc == r_n - 1'b1);
  assign w_load_out = (r_state == S_NORM) && (r_rd < r_n)
                   && (!r_ovld || out_ready);
  assign w_n_lat    = (hidden_dim > MAXN) ? MAXN : hidden_dim;

  assign w_sq  = $signed(in_data) * $signed(in_data);
  assign w_div = (r_n == '0) ? ACC_WIDTH'(1)
               : {{(ACC_WIDTH-IDXW-1){1'b0}}, r_n};
  assign w_mean = r_sum / $signed(w_div);
  assign w_msq  = r_sumsq / w_div;

  // Variance, clamped at zero and at the top of the rsqrt table.
  always_comb begin
    w_var = $signed(r_msq);
    if (!r_rms) w_var = $signed(r_msq) - r_mean * r_mean;
    w_varc = w_var;
    if (w_var < 0) w_varc = '0;
    w_idx = w_varc[LIDXW-1:0];
    if (w_varc > LMAX) w_idx = LIDXW'(LUT_DEPTH - 1);
  end

  assign w_xr = r_buf[r_rd[IDXW-1:0]];
  assign w_gr = r_gamma[r_rd[IDXW-1:0]];
  assign w_br = r_beta[r_rd[IDXW-1:0]];

  assign w_diff  = {{(W2-DATA_WIDTH){w_xr[DATA_WIDTH-1]}}, w_xr}
                 - {{(W2-ACC_WIDTH){r_mean[ACC_WIDTH-1]}}, r_mean};
  assign w_rsx   = {{(W2-32){1'b0}}, r_rs};
  assign w_gx    = {{(W2-DATA_WIDTH){w_gr[DATA_WIDTH-1]}}, w_gr};
  assign w_bx    = {{(W2-DATA_WIDTH){w_br[DATA_WIDTH-1]}}, w_br};
  assign w_nprod = w_diff * w_rsx;
  assign w_n     = w_nprod >>> 16;
  assign w_sprod = w_n * w_gx;
  assign w_s     = w_sprod >>> GAMMA_FRAC;
  assign w_y     = r_rms ? w_s : (w_s + w_bx);

  // Saturate the normalised value into the element range.
  always_comb begin
    w_sat = w_y[DATA_WIDTH-1:0];
    if (w_y > SMAX) w_sat = SMAX[DATA_WIDTH-1:0];
    else if (w_y < SMIN) w_sat = SMIN[DATA_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; clear overrides everything.
  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (start)
            w_next = (hidden_dim == '0) ? S_FINISH : S_LOAD;
        S_LOAD:   if (w_last_in) w_next = S_STATS1;
        S_STATS1: w_next = S_STATS2;
        S_STATS2: w_next = S_NORM;
        S_NORM:   if (w_last_out) w_next = S_FINISH;
        S_FINISH: w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Row datapath: accumulate, derive statistics, drive output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rms   <= 1'b0;
      r_n     <= '0;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_oc    <= '0;
      r_sum   <= '0;
      r_sumsq <= '0;
      r_mean  <= '0;
      r_msq   <= '0;
      r_rs    <= '0;
      r_out   <= '0;
      r_ovld  <= 1'b0;
    end else if (clear) begin
      r_cnt   <= '0;
      r_rd    <= '0;
      r_oc    <= '0;
      r_sum   <= '0;
      r_sumsq <= '0;
      r_ovld  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rms   <= mode_rms;
            r_n     <= w_n_lat;
            r_cnt   <= '0;
            r_rd    <= '0;
            r_oc    <= '0;
            r_sum   <= '0;
            r_sumsq <= '0;
          end
        end
        S_LOAD: begin
          if (w_in_hs) begin
            r_sum <= r_sum
              + {{(ACC_WIDTH-DATA_WIDTH){in_data[DATA_WIDTH-1]}},
                 in_data};
            r_sumsq <= r_sumsq
              + {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, w_sq};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STATS1: begin
          r_mean <= r_rms ? '0 : w_mean;
          r_msq  <= w_msq;
        end
        S_STATS2: begin
          r_rs <= w_lut[w_idx];
        end
        S_NORM: begin
          if (w_load_out) begin
            r_out  <= w_sat;
            r_ovld <= 1'b1;
            r_rd   <= r_rd + 1'b1;
          end else if (w_out_hs) begin
            r_ovld <= 1'b0;
          end
          if (w_out_hs) r_oc <= r_oc + 1'b1;
        end
        default: begin
          r_ovld <= 1'b0;
        end
      endcase
    end
  end

  // Row buffer write on each accepted input beat.
  always_ff @(posedge clk) begin
    if (w_in_hs) r_buf[r_cnt[IDXW-1:0]] <= in_data;
  end

  // Parameter RAM, writable only while idle.
  always_ff @(posedge clk) begin
    if (param_we && (r_state == S_IDLE)) begin
      r_gamma[param_addr] <= gamma_in;
      r_beta[param_addr]  <= beta_in;
    end
  end

endmodule

// File: tb/tb_norm_engine.sv
// Bench for norm_engine: random rows against a real-arithmetic
// normalisation model, plus reset, clear, backpressure and edge rows.
module tb_norm_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mode_rms;
  logic [6:0] hidden_dim;
  logic       clear;
  logic       busy;
  logic       done;
  logic       param_we;
  logic [5:0] param_addr;
  logic [7:0] gamma_in;
  logic [7:0] beta_in;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  int total = 0;
  int bad   = 0;
  int xs   [64];
  int gm   [64];
  int bm   [64];
  int expv [64];
  bit lock_probe = 1'b0;
  int last_done_cyc;

  always #5 clk = ~clk;

  norm_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mode_rms(mode_rms), .hidden_dim(hidden_dim),
    .clear(clear), .busy(busy), .done(done),
    .param_we(param_we), .param_addr(param_addr),
    .gamma_in(gamma_in), .beta_in(beta_in),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic longint rsqrt_ref(longint v);
    real r;
    r = 65536.0 / $sqrt(real'(v + 1));
    return longint'($rtoi(r + 0.5));
  endfunction

  // Normalise xs[0..n-1] with the current parameter mirror.
  function automatic void build_expected(int n, bit rms);
    longint sum, sq, mean, msq, var_, rs, nn, s, y;
    sum = 0;
    sq  = 0;
    for (int i = 0; i < n; i++) begin
      sum += xs[i];
      sq  += xs[i] * xs[i];
    end
    mean = 0;
    msq  = 0;
    if (n > 0) begin
      mean = rms ? 0 : sum / n;
      msq  = sq / n;
    end
    var_ = rms ? msq : msq - mean * mean;
    if (var_ < 0) var_ = 0;
    if (var_ > 1023) var_ = 1023;
    rs = rsqrt_ref(var_);
    for (int i = 0; i < n; i++) begin
      nn = ((xs[i] - mean) * rs) >>> 16;
      s  = (nn * gm[i]) >>> 6;
      y  = rms ? s : s + bm[i];
      if (y > 127) y = 127;
      if (y < -128) y = -128;
      expv[i] = int'(y);
    end
  endfunction

  task automatic set_params(input int n, input bit rnd,
                            input int g, input int b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      param_we   = 1'b1;
      param_addr = i[5:0];
      gm[i] = rnd ? int'($urandom_range(255)) - 128 : g;
      bm[i] = rnd ? int'($urandom_range(255)) - 128 : b;
      gamma_in = gm[i][7:0];
      beta_in  = bm[i][7:0];
    end
    @(negedge clk);
    param_we = 1'b0;
  endtask

  task automatic rand_xs(input int n);
    for (int i = 0; i < n; i++)
      xs[i] = int'($urandom_range(255)) - 128;
  endtask

  task automatic run_row(input int nreq, input bit rms,
                         input int gap, input int stall,
                         input bit stall3, output int lat);
    int n, ip, op, cyc, last_in, first_ov, dones;
    int stall_left, prev_data, done_cyc;
    bit prev_stall, fin;
    n = (nreq > 64) ? 64 : nreq;
    build_expected(n, rms);
    @(negedge clk);
    start      = 1'b1;
    mode_rms   = rms;
    hidden_dim = nreq[6:0];
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ip = 0; op = 0; cyc = 0; last_in = -1; first_ov = -1;
    dones = 0; stall_left = 0; prev_data = 0; done_cyc = -1;
    prev_stall = 1'b0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || int'($signed(out_data)) != prev_data) begin
          bad++;
          $display("FAIL hold cyc=%0d valid=%0b data=%0d want=%0d",
                   cyc, out_valid, $signed(out_data), prev_data);
        end
      end
      if (done === 1'b1) begin
        dones++;
        done_cyc = cyc;
      end
      if (out_valid === 1'b1 && first_ov < 0) begin
        first_ov = cyc;
        if (stall3) stall_left = 3;
      end
      in_valid = (ip < n) && ($urandom_range(99) >= gap);
      in_data  = (ip < n) ? xs[ip][7:0] : 8'h00;
      if (stall3) begin
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        out_ready = ($urandom_range(99) >= stall);
      end
      param_we   = lock_probe && (in_ready === 1'b1);
      param_addr = 6'd0;
      gamma_in   = 8'h11;
      beta_in    = 8'h22;
      if (in_valid && in_ready === 1'b1) begin
        ip++;
        if (ip == n) last_in = cyc;
      end
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        if (op >= n) begin
          bad++;
          $display("FAIL extra_beat idx=%0d got=%0d want=none",
                   op, $signed(out_data));
        end else if (int'($signed(out_data)) != expv[op]) begin
          bad++;
          $display("FAIL out[%0d] n=%0d rms=%0b got=%0d want=%0d",
                   op, n, rms, $signed(out_data), expv[op]);
        end
        op++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_data  = int'($signed(out_data));
      if (dones > 0 && cyc >= done_cyc + 2) fin = 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    param_we  = 1'b0;
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL row_timeout n=%0d got=%0d beats want=%0d", n, op, n);
    end
    total++;
    if (op != n) begin
      bad++;
      $display("FAIL beat_count got=%0d want=%0d", op, n);
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL done_pulses got=%0d want=1", dones);
    end
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after busy=%0b valid=%0b want=0,0",
               busy, out_valid);
    end
    lat = (first_ov >= 0 && last_in >= 0) ? first_ov - last_in - 1 : -1;
    last_done_cyc = done_cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; mode_rms = 0; hidden_dim = 0; clear = 0;
    param_we = 0; param_addr = 0; gamma_in = 0; beta_in = 0;
    in_data = 0; in_valid = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", done); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%0d want=0", out_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_spec_vectors();
    int lat;
    set_params(4, 1'b0, 64, 0);
    xs[0] = -2; xs[1] = -1; xs[2] = 1; xs[3] = 2;
    run_row(4, 1'b0, 0, 0, 1'b0, lat);
    total++;
    if (lat != 3) begin
      bad++;
      $display("FAIL first_out_latency got=%0d want=3", lat);
    end
    set_params(4, 1'b0, 64, 5);
    for (int i = 0; i < 4; i++) xs[i] = 4;
    run_row(4, 1'b0, 0, 0, 1'b0, lat);
    run_row(4, 1'b1, 0, 0, 1'b0, lat);
    set_params(2, 1'b0, 127, 127);
    xs[0] = -128; xs[1] = 127;
    run_row(2, 1'b0, 0, 0, 1'b0, lat);
  endtask

  task automatic test_backpressure();
    int lat;
    set_params(8, 1'b1, 0, 0);
    rand_xs(8);
    run_row(4, 1'b0, 0, 0, 1'b1, lat);
    rand_xs(8);
    run_row(8, 1'b1, 30, 70, 1'b0, lat);
  endtask

  task automatic test_reset_mid();
    int lat, w;
    rand_xs(8);
    @(negedge clk);
    start = 1'b1; mode_rms = 1'b0; hidden_dim = 7'd8;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = xs[i][7:0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_reach_norm got=%0b want=1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%0b want=0", busy); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%0b want=0", out_valid); end
    if (out_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%0d want=0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    rand_xs(8);
    run_row(8, 1'b0, 10, 20, 1'b0, lat);
  endtask

  task automatic test_clear();
    int lat, w, dn;
    rand_xs(6);
    @(negedge clk);
    start = 1'b1; mode_rms = 1'b0; hidden_dim = 7'd6;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = xs[i][7:0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL clr_busy got=%0b want=0", busy); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%0b want=0", out_valid); end
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    total++;
    if (dn != 0) begin bad++; $display("FAIL clr_done got=%0d want=0", dn); end
    rand_xs(6);
    run_row(6, 1'b1, 20, 20, 1'b0, lat);
  endtask

  task automatic test_zero_and_lock();
    int lat;
    run_row(0, 1'b0, 0, 0, 1'b0, lat);
    total++;
    if (last_done_cyc < 1 || last_done_cyc > 2) begin
      bad++;
      $display("FAIL zero_done_cyc got=%0d want=1..2", last_done_cyc);
    end
    set_params(4, 1'b0, 64, 3);
    rand_xs(4);
    lock_probe = 1'b1;
    run_row(4, 1'b0, 40, 0, 1'b0, lat);
    lock_probe = 1'b0;
    rand_xs(4);
    run_row(4, 1'b0, 0, 0, 1'b0, lat);
  endtask

  task automatic test_oversize();
    int lat;
    set_params(64, 1'b1, 0, 0);
    rand_xs(64);
    run_row(100, 1'b0, 10, 10, 1'b0, lat);
  endtask

  task automatic test_random();
    int lat, n;
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(64, 1));
      if (r % 3 == 0) set_params(64, 1'b1, 0, 0);
      rand_xs(n);
      run_row(n, 1'($urandom_range(1)),
              int'($urandom_range(50)), int'($urandom_range(60)),
              1'b0, lat);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_backpressure();
    test_reset_mid();
    test_clear();
    test_zero_and_lock();
    test_oversize();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
